// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BURST_DEF = 8;
  localparam int BEAT_W    = $clog2(BURST_DEF);

  localparam logic P_DCACHE = 1'b0;
  localparam logic P_ICACHE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the last winner loses the next tie.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (update_i && (|gnt_o)) last_d = gnt_o[1];
  end

  // Reset to port 1 so port 0 wins the very first tie.
  always_ff @(posedge clock) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the d_cache and i_cache paths, one
// whole-line burst at a time, with round-robin arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int MWIDTH = 64,
  parameter int BURST  = BURST_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [AWIDTH-1:0] r0_addr,
  input  logic [MWIDTH-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_wready,
  output logic              r0_rvalid,
  output logic [MWIDTH-1:0] r0_rdata,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [AWIDTH-1:0] r1_addr,
  input  logic [MWIDTH-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_wready,
  output logic              r1_rvalid,
  output logic [MWIDTH-1:0] r1_rdata,
  output logic              r1_done,
  output logic [AWIDTH-1:0] mrdaddress,
  output logic              mrden,
  output logic [AWIDTH-1:0] mwraddress,
  output logic              mwren,
  output logic [MWIDTH-1:0] mdout,
  input  logic [MWIDTH-1:0] mq
);

  localparam int            BW        = $clog2(BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic              rd_pend_q, wr_pend_q;
  logic [AWIDTH-1:0] wr_addr_q;
  logic [MWIDTH-1:0] wr_data_q;

  logic [1:0]        pick;
  logic              start, issue_rd, issue_wr, own0, own1;
  logic [AWIDTH-1:0] beat_addr, sel_addr;

  rr_arbiter2 u_rr (
    .clock    (clock),
    .reset    (reset),
    .req_i    ({r1_req, r0_req}),
    .update_i (state_q == IDLE),
    .gnt_o    (pick)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    owner_d  = owner_q;
    we_d     = we_q;
    base_d   = base_q;
    start    = (state_q == IDLE) && (|pick);
    sel_addr = pick[1] ? r1_addr : r0_addr;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          beat_d  = '0;
          owner_d = pick[1];
          we_d    = pick[1] ? r1_we : r0_we;
          base_d  = sel_addr & ~AWIDTH'(BURST - 1);
        end
      end
      ISSUE: begin
        beat_d = beat_q + BW'(1);
        if (beat_q == LAST_BEAT) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own0       = (state_q != IDLE) && (owner_q == P_DCACHE);
    own1       = (state_q != IDLE) && (owner_q == P_ICACHE);
    issue_rd   = (state_q == ISSUE) && !we_q;
    issue_wr   = (state_q == ISSUE) && we_q;
    beat_addr  = base_q + AWIDTH'(beat_q);
    r0_gnt     = own0;
    r1_gnt     = own1;
    r0_wready  = own0 && issue_wr;
    r1_wready  = own1 && issue_wr;
    r0_rvalid  = own0 && rd_pend_q;
    r1_rvalid  = own1 && rd_pend_q;
    r0_rdata   = r0_rvalid ? mq : '0;
    r1_rdata   = r1_rvalid ? mq : '0;
    r0_done    = own0 && (state_q == DRAIN);
    r1_done    = own1 && (state_q == DRAIN);
    mrden      = issue_rd;
    mrdaddress = beat_addr;
    mwren      = wr_pend_q;
    mwraddress = wr_addr_q;
    mdout      = wr_data_q;
  end

  // Write beats are registered once, so memory sees them one cycle after wready.
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q    <= '0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      base_q    <= '0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      beat_q    <= beat_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      base_q    <= base_d;
      rd_pend_q <= issue_rd;
      wr_pend_q <= issue_wr;
      if (issue_wr) begin
        wr_addr_q <= beat_addr;
        wr_data_q <= owner_q ? r1_wdata : r0_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int B = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [31:0] addr  [2];
  logic [63:0] wdata [2];
  logic        r0_gnt, r0_wready, r0_rvalid, r0_done;
  logic        r1_gnt, r1_wready, r1_rvalid, r1_done;
  logic [63:0] r0_rdata, r1_rdata, mdout, mq;
  logic [31:0] mrdaddress, mwraddress;
  logic        mrden, mwren;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_gnt(r0_gnt), .r0_wready(r0_wready), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_done(r0_done),
    .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_gnt(r1_gnt), .r1_wready(r1_wready), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_done(r1_done),
    .mrdaddress(mrdaddress), .mrden(mrden), .mwraddress(mwraddress),
    .mwren(mwren), .mdout(mdout), .mq(mq)
  );

  always #5 clock = ~clock;

  // Backing memory: 64 words, registered read.
  logic [63:0] mem [64];
  always @(posedge clock) begin
    if (mrden) mq <= mem[mrdaddress[5:0]];
    if (mwren) mem[mwraddress[5:0]] <= mdout;
  end

  // Reference model: one transaction described by owner/direction/base and
  // the offset of the current cycle from the sampling cycle.
  logic [63:0] ref_mem [64];
  logic        m_act, m_own, m_we, m_last;
  int          m_off;
  logic [31:0] m_base;
  logic [63:0] m_prev;
  int          wcnt [2];
  logic [63:0] wpat [2];

  int n_pass = 0, n_tot = 0, cyc = 0;
  logic prev_any = 1'b0;
  logic gq[$];
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    else
      n_pass++;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step();
    logic [1:0]  e_gnt, e_wr, e_rv, e_dn;
    logic        e_rden, e_wren;
    logic [31:0] e_ra, e_wa;
    logic [63:0] e_rd, e_md;
    e_gnt = '0; e_wr = '0; e_rv = '0; e_dn = '0;
    e_rden = 1'b0; e_wren = 1'b0; e_ra = '0; e_wa = '0; e_rd = '0; e_md = '0;
    if (m_act) begin
      e_gnt[m_own] = 1'b1;
      if (m_we) begin
        if (m_off <= B) e_wr[m_own] = 1'b1;
        if (m_off >= 2) begin
          e_wren = 1'b1;
          e_wa   = m_base + 32'(m_off - 2);
          e_md   = m_prev;
        end
      end else begin
        if (m_off <= B) begin
          e_rden = 1'b1;
          e_ra   = m_base + 32'(m_off - 1);
        end
        if (m_off >= 2) begin
          e_rv[m_own] = 1'b1;
          e_rd = ref_mem[6'(m_base + 32'(m_off - 2))];
        end
      end
      if (m_off == B + 1) e_dn[m_own] = 1'b1;
    end
    wdata[0] = wpat[0] + 64'(wcnt[0]);
    wdata[1] = wpat[1] + 64'(wcnt[1]);
    #1;
    chk("gnt",    64'({r1_gnt, r0_gnt}),       64'(e_gnt));
    chk("wready", 64'({r1_wready, r0_wready}), 64'(e_wr));
    chk("rvalid", 64'({r1_rvalid, r0_rvalid}), 64'(e_rv));
    chk("done",   64'({r1_done, r0_done}),     64'(e_dn));
    chk("mrden",  64'(mrden), 64'(e_rden));
    chk("mwren",  64'(mwren), 64'(e_wren));
    if (e_rden) chk("mrdaddress", 64'(mrdaddress), 64'(e_ra));
    if (e_wren) begin
      chk("mwraddress", 64'(mwraddress), 64'(e_wa));
      chk("mdout", mdout, e_md);
    end
    if (e_rv[0]) chk("r0_rdata", r0_rdata, e_rd);
    else if (!(m_act && m_own == 1'b0)) chk("r0_rdata_idle", r0_rdata, 64'd0);
    if (e_rv[1]) chk("r1_rdata", r1_rdata, e_rd);
    else if (!(m_act && m_own == 1'b1)) chk("r1_rdata_idle", r1_rdata, 64'd0);
    if ((r0_gnt || r1_gnt) && !prev_any) gq.push_back(r1_gnt);
    prev_any = r0_gnt || r1_gnt;
    done_cnt += int'(r0_done) + int'(r1_done);

    @(posedge clock);
    if (m_act && m_we && m_off >= 2) ref_mem[6'(m_base + 32'(m_off - 2))] = m_prev;
    if (reset) begin
      m_act  = 1'b0;
      m_last = 1'b1;
    end else if (m_act) begin
      if (m_we && m_off <= B) begin
        m_prev = wdata[m_own];
        wcnt[m_own]++;
      end
      m_off++;
      if (m_off > B + 1) m_act = 1'b0;
    end else if (req != 2'b00) begin
      m_own  = (req == 2'b11) ? !m_last : req[1];
      m_last = m_own;
      m_act  = 1'b1;
      m_off  = 1;
      m_we   = we[m_own];
      m_base = addr[m_own] & ~32'(B - 1);
      wcnt   = '{0, 0};
    end
    @(negedge clock);
    cyc++;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0, a1;
    logic [63:0] wp0, wp1;
    logic        own;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{2'b01, 2'b00, 32'h13, 32'h0,  64'h0,  64'h0,  1'b0};
    vecs[1] = '{2'b10, 2'b10, 32'h0,  32'h20, 64'h0,  64'hA0, 1'b1};
    vecs[2] = '{2'b11, 2'b00, 32'h08, 32'h30, 64'h0,  64'h0,  1'b0};
    vecs[3] = '{2'b11, 2'b01, 32'h28, 32'h10, 64'hD0, 64'h0,  1'b1};
    vecs[4] = '{2'b11, 2'b00, 32'h20, 32'h28, 64'h0,  64'h0,  1'b0};
    vecs[5] = '{2'b10, 2'b00, 32'h0,  32'h20, 64'h0,  64'h0,  1'b1};

    for (int i = 0; i < 64; i++) begin
      mem[i]     = 64'(i);
      ref_mem[i] = 64'(i);
    end
    mq = '0;
    reset = 1'b1; req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wpat[0] = '0; wpat[1] = '0;
    wdata[0] = '0; wdata[1] = '0;
    wcnt = '{0, 0};
    m_act = 1'b0; m_last = 1'b1; m_own = 1'b0; m_we = 1'b0; m_off = 0;
    m_base = '0; m_prev = '0;

    @(negedge clock);
    step();
    step();
    reset = 1'b0;

    // Directed table: each entry is one arbitration decision plus a full burst.
    for (int v = 0; v < 6; v++) begin
      req = vecs[v].req; we = vecs[v].we;
      addr[0] = vecs[v].a0; addr[1] = vecs[v].a1;
      wpat[0] = vecs[v].wp0; wpat[1] = vecs[v].wp1;
      step();
      req = '0;
      #2 chk($sformatf("vec%0d_owner", v), 64'({r1_gnt, r0_gnt}),
             vecs[v].own ? 64'd2 : 64'd1);
      for (int c = 0; c < B + 1; c++) step();
    end
    chk("readback_a0", mem[32], 64'hA0);
    chk("readback_a7", mem[39], 64'hA7);

    // Request dropped mid-burst still runs to completion, no regrant.
    done_cnt = 0;
    req = 2'b01; we = 2'b00; addr[0] = 32'h40;
    step(); step(); step();
    req = 2'b00;
    for (int c = 0; c < 12; c++) step();
    chk("drop_req_done_count", 64'(done_cnt), 64'd1);

    // Reset in cycle 4 of a write burst aborts it.
    done_cnt = 0;
    req = 2'b10; we = 2'b10; addr[1] = 32'h30; wpat[1] = 64'hB0;
    step();
    req = 2'b00;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #2;
    chk("rst_mwren", 64'(mwren), 64'd0);
    chk("rst_gnt", 64'({r1_gnt, r0_gnt}), 64'd0);
    step();
    step();
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    req = 2'b01; we = 2'b00; addr[0] = 32'h30;
    step();
    req = 2'b00;
    for (int c = 0; c < B + 2; c++) step();
    chk("post_rst_read_done", 64'(done_cnt), 64'd1);

    // Port 0 holds req; port 1 asks once and must get the next slot.
    gq.delete();
    for (int s = 0; s < 32; s++) begin
      req[0] = (s <= 20);
      req[1] = (s >= 3 && s <= 11);
      step();
    end
    chk("alt_count", 64'(gq.size()), 64'd3);
    if (gq.size() == 3) begin
      chk("alt_g0", 64'(gq[0]), 64'd0);
      chk("alt_g1", 64'(gq[1]), 64'd1);
      chk("alt_g2", 64'(gq[2]), 64'd0);
    end

    // Random traffic, occasional reset.
    for (int s = 0; s < 400; s++) begin
      reset = ($urandom_range(0, 99) == 0);
      req = 2'($urandom_range(0, 3));
      we  = 2'($urandom_range(0, 3));
      addr[0] = $urandom; addr[1] = $urandom;
      wpat[0] = {$urandom, $urandom}; wpat[1] = {$urandom, $urandom};
      step();
    end
    reset = 1'b0; req = '0;
    for (int c = 0; c < B + 2; c++) step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backing `mem` port (64-bit word-addressed, registered read data, 1-cycle read latency) between two cache requesters.
- Port 0 is the d_cache refill/writeback path; port 1 is the i_cache refill path (generic read/write capable).
- Grants one whole-line burst transaction at a time, using round-robin arbitration.
- Sequences burst addresses and strobes, and returns read beats and a completion pulse to the owner.

Parameters:
- AWIDTH, 32, address width of requester and memory ports.
- MWIDTH, 64, memory word width.
- BURST, 8, memory words per cache line (power of two, ≥2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_req  in  1  port 0 transaction request; sampled only in IDLE.
- r0_we  in  1  port 0 direction: 1=write burst, 0=read burst.
- r0_addr  in  AWIDTH  port 0 line base word address; low log2(BURST) bits ignored (treated as 0).
- r0_wdata  in  MWIDTH  port 0 write beat; consumed in a cycle where r0_wready=1.
- r0_gnt  out  1  port 0 owns memory.
- r0_wready  out  1  port 0 write beat consumed this cycle.
- r0_rvalid  out  1  port 0 read beat valid.
- r0_rdata  out  MWIDTH  port 0 read beat data.
- r0_done  out  1  port 0 transaction complete, 1-cycle pulse.
- r1_* : identical set for port 1.
- mrdaddress  out  AWIDTH  memory read address.
- mrden  out  1  memory read enable.
- mwraddress  out  AWIDTH  memory write address.
- mwren  out  1  memory write enable.
- mdout  out  MWIDTH  memory write data.
- mq  in  MWIDTH  memory read data; valid 1 cycle after mrden.

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, last_grant=1 (so port 0 wins the first tie).
- Reset mid-burst aborts immediately. No further mrden/mwren. No done pulse is issued.
- States:
  - IDLE: if any req is high at the edge, select the owner and latch owner, we, and base = addr with low bits cleared. Go to ISSUE with beat=0.
  - ISSUE: one beat per cycle. After beat BURST-1, go to DRAIN.
  - DRAIN: one cycle for the last read-data return or last registered write. Then go to IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port other than last_grant wins.
  - last_grant updates on each grant.
  - req is ignored outside IDLE. Deasserting req mid-burst does not cancel the transaction.
- Timing, with cycle 0 = IDLE cycle in which req is sampled:
  - gnt is high in cycles 1..BURST+1 inclusive.
  - In IDLE, all gnt outputs are 0.
- Read burst:
  - mrden=1 with mrdaddress=base+k in cycle k+1, for k=0..BURST-1.
  - owner rvalid=1 with rdata=mq in cycles 2..BURST+1.
  - done is asserted together with the last rvalid (cycle BURST+1).
- Write burst:
  - owner wready=1 in cycles 1..BURST (combinational from state). The arbiter registers wdata at that edge.
  - mwren=1, mwraddress=base+k, mdout=beat-k data in cycle k+2.
  - done is asserted with the last mwren (cycle BURST+1).
- Read and write enables are never both high.
- Non-owner wready/rvalid/done/gnt stay 0. Non-owner rdata = 0.
- Back-to-back: the IDLE cycle after done samples requests again. The minimum gap between bursts is 1 idle cycle; transaction period is BURST+2 cycles.
- Address arithmetic: base + beat computed in AWIDTH bits. Alignment guarantees no carry out of the low bits.
- mrdaddress/mwraddress/mdout hold their last value when their enable is 0; the value is don't-care for checking.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN}
  - BEAT_W = log2(BURST)
  - port index constants P_DCACHE=0, P_ICACHE=1
- One natural sub-module: rr_arbiter2 (2-way round-robin pick with last_grant register, update-on-grant input). Everything else stays in mem_port_arbiter.

Test Plan:
- Single read, port 0, r0_addr=0x0000_0013, mem[16..23]=0x10..0x17 → mrdaddress 16..23 in cycles 1..8; r0_rvalid cycles 2..9 with rdata 0x10..0x17; r0_done at cycle 9; r1_* all 0.
- Single write, port 1, r1_addr=0x20, wdata=0xA0..0xA7 on successive wready → mwren cycles 2..9, mwraddress 0x20..0x27, mdout 0xA0..0xA7. Memory readback matches. r1_done at cycle 9.
- Simultaneous req from both ports after reset → port 0 is granted first. Port 1 is granted in the IDLE cycle after r0_done (gnt at cycle 11). Repeat the tie → port 0 is granted again (alternation).
- Port 0 holds req continuously while port 1 requests once → grants alternate 0,1,0. Port 1 is never starved.
- r0_req drops in cycle 3 of a read burst → burst still completes all 8 beats and done. No new grant follows.
- reset asserted in cycle 4 of a write burst → next cycle: mwren=0, all gnt=0, state IDLE, no done. A fresh read then completes normally.
